msj_duty_guard: RTL
===================

Name: msj_duty_guard

Overview:
- Per-motor safety and slew stage between the PD controller duty output and the PWM generator of the MSJ platform.
- Accepts each new duty sample on the sensor-cycle strobe and limits its rate of change.
- Ramps the duty to zero on disable or emergency-off, and forces zero with a latched fault if samples stop arriving (watchdog).
- Drives the duty value and the latch strobe consumed by the PWM block.

Parameters:
WATCHDOG_CYCLES, 100_000, clocks without duty_valid in RUN before timeout fault (2 ms at 50 MHz)
RAMP_STEP, 64, magnitude subtracted from |duty_out| per ramp tick
RAMP_DIV, 5_000, clocks between ramp ticks in RAMP state

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run request from the control register file
duty_in  input  32  signed duty from the PD controller
duty_valid  input  1  one-cycle strobe: duty_in is a new sample (sensor cycle)
max_step  input  32  unsigned max |change| per accepted sample; 0 = unlimited
emergency_off  input  1  level; high = emergency stop active
clear_fault  input  1  one-cycle strobe to leave FAULT
duty_out  output  32  signed duty to the PWM block
duty_strobe  output  1  one-cycle pulse whenever duty_out is written; drives PWM ena
state  output  2  0 DISABLED, 1 RUN, 2 RAMP, 3 FAULT
fault_code  output  2  0 none, 1 emergency, 2 watchdog timeout

Behaviour:
- Reset (synchronous, clock edge with reset=1): duty_out=0, duty_strobe=0, state=DISABLED, fault_code=0, watchdog counter=0, ramp counter=0.
- Registered outputs; latency of one clock from input event to duty_out/duty_strobe.
- duty_strobe is high for exactly one cycle per duty_out write, including writes of an unchanged value. It is never high in two consecutive cycles except on consecutive duty_valid.
- Event priority within one cycle: reset > emergency_off > watchdog expiry > enable low > duty_valid.

DISABLED:
- duty_out holds 0; no strobes.
- Moves to RUN when enable=1, emergency_off=0 and fault_code=0; the watchdog is cleared on entry.
- emergency_off=1 has no effect here; the PWM is already at 0.

RUN:
- On duty_valid, delta = duty_in - duty_out, computed 33-bit signed (no overflow).
- If max_step==0 or |delta| <= max_step: duty_out = duty_in.
- Otherwise: duty_out = duty_out + sign(delta)*max_step.
- Either way, duty_strobe=1 next cycle.
- Watchdog counter clears on duty_valid, else increments. When it reaches WATCHDOG_CYCLES: duty_out=0 with strobe, fault_code=2, state=FAULT.
- emergency_off=1: go to RAMP with fault_code=1; a duty_valid in the same cycle is discarded.
- enable=0: go to RAMP with fault_code unchanged (0); a duty_valid in the same cycle is discarded.

RAMP:
- duty_in and duty_valid are ignored; the watchdog is frozen.
- The ramp counter counts 0..RAMP_DIV-1. On wrap, duty_out moves toward 0 by RAMP_STEP, clamped at 0 with no sign crossing, and duty_strobe is pulsed.
- When duty_out==0 (including on entry): go to FAULT if fault_code!=0, else DISABLED.
- emergency_off rising during a disable ramp sets fault_code=1; the ramp continues and ends in FAULT.
- enable reasserting during RAMP does not abort the ramp.

FAULT:
- duty_out=0; no strobes.
- Leave to DISABLED only on clear_fault=1 with emergency_off=0; this clears fault_code.
- clear_fault with emergency_off=1 is ignored.
- clear_fault in any other state is ignored.

Reset mid-ramp or mid-fault: immediate return to the reset values. No ramp is performed; the PWM block is reset on the same reset.

Test Plan:
- Slew limiting: max_step=100, duty_out=0, duty_valid with duty_in=250 three times -> duty_out 100, 200, 250, each one clock after its strobe; duty_in=-50 with max_step=0 -> duty_out=-50 in one step.
- Watchdog (WATCHDOG_CYCLES=20): RUN with duty_out=500, no duty_valid for 20 clocks -> duty_out=0, strobe once, state=3, fault_code=2. A duty_valid at clock 19 instead keeps RUN.
- Emergency ramp (RAMP_STEP=64, RAMP_DIV=4): duty_out=-200, emergency_off=1 -> state=2; duty_out -136, -72, -8, 0 at 4-clock spacing -> state=3, fault_code=1. Any sign crossing or overshoot fails.
- Disable ramp: duty_out=130, enable=0 -> 66, 2, 0 then state=0, fault_code=0. A simultaneous duty_valid with duty_in=900 is discarded.
- Fault clear: in FAULT, clear_fault with emergency_off=1 -> stays 3; emergency_off=0 then clear_fault -> state=0, fault_code=0; enable=1 -> RUN next clock.
- Reset mid-ramp: synchronous reset at duty_out=72 in RAMP -> next edge duty_out=0, state=0, duty_strobe=0, counters 0.

Source files
------------

// File: rtl/msj_duty_guard.sv
// Per-motor duty guard between the PD controller and the PWM generator:
// slew-limits accepted samples, ramps to zero on stop requests and trips on a lost sample stream.
module msj_duty_guard #(
  parameter int WATCHDOG_CYCLES = 100_000,
  parameter int RAMP_STEP       = 64,
  parameter int RAMP_DIV        = 5_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [31:0] duty_in,
  input  logic               duty_valid,
  input  logic        [31:0] max_step,
  input  logic               emergency_off,
  input  logic               clear_fault,
  output logic signed [31:0] duty_out,
  output logic               duty_strobe,
  output logic        [1:0]  state,
  output logic        [1:0]  fault_code
);

  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam int RD_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [RD_W-1:0] RAMP_LAST = RD_W'(RAMP_DIV - 1);

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_EMERG = 2'd1;
  localparam logic [1:0] FC_WDOG  = 2'd2;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_RAMP     = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t              fsm_state;
  state_t              fsm_next;
  logic signed [31:0]  duty_next;
  logic                strobe_next;
  logic        [1:0]   fault_next;
  logic        [1:0]   fault_eff;
  logic [WD_W-1:0]     wd_cnt;
  logic [WD_W-1:0]     wd_next;
  logic [RD_W-1:0]     ramp_cnt;
  logic [RD_W-1:0]     ramp_next;

  // Move cur toward target by at most limit; the 34-bit delta cannot overflow.
  function automatic logic signed [31:0] slew_step(
    input logic signed [31:0] cur,
    input logic signed [31:0] target,
    input logic        [31:0] limit
  );
    logic signed [33:0] delta;
    logic signed [33:0] mag;
    logic signed [33:0] lim;
    logic        [31:0] moved;
    delta = $signed({{2{target[31]}}, target}) - $signed({{2{cur[31]}}, cur});
    mag   = delta[33] ? -delta : delta;
    lim   = $signed({2'b00, limit});
    if ((limit == 32'd0) || (mag <= lim)) begin
      slew_step = target;
    end else if (delta[33]) begin
      moved     = cur - limit;
      slew_step = $signed(moved);
    end else begin
      moved     = cur + limit;
      slew_step = $signed(moved);
    end
  endfunction

  // One ramp tick toward zero, clamped so the sign never flips.
  function automatic logic signed [31:0] ramp_toward_zero(input logic signed [31:0] cur);
    logic signed [31:0] step;
    step = 32'(RAMP_STEP);
    if (cur > step) begin
      ramp_toward_zero = cur - step;
    end else if (cur < -step) begin
      ramp_toward_zero = cur + step;
    end else begin
      ramp_toward_zero = 32'sd0;
    end
  endfunction

  assign state = fsm_state;

  // Next-state, next-duty and counter logic; event priority is encoded in the if-chains.
  always_comb begin
    fsm_next    = fsm_state;
    duty_next   = duty_out;
    strobe_next = 1'b0;
    fault_next  = fault_code;
    fault_eff   = fault_code;
    wd_next     = wd_cnt;
    ramp_next   = ramp_cnt;
    case (fsm_state)
      ST_DISABLED: begin
        duty_next = 32'sd0;
        wd_next   = {WD_W{1'b0}};
        if (enable && !emergency_off && (fault_code == FC_NONE)) begin
          fsm_next = ST_RUN;
        end else begin
          fsm_next = ST_DISABLED;
        end
      end
      ST_RUN: begin
        if (emergency_off) begin
          fsm_next   = ST_RAMP;
          fault_next = FC_EMERG;
          ramp_next  = {RD_W{1'b0}};
        end else if (!duty_valid && (wd_cnt == WD_LAST)) begin
          fsm_next    = ST_FAULT;
          fault_next  = FC_WDOG;
          duty_next   = 32'sd0;
          strobe_next = 1'b1;
          wd_next     = {WD_W{1'b0}};
        end else if (!enable) begin
          fsm_next  = ST_RAMP;
          ramp_next = {RD_W{1'b0}};
        end else if (duty_valid) begin
          duty_next   = slew_step(duty_out, duty_in, max_step);
          strobe_next = 1'b1;
          wd_next     = {WD_W{1'b0}};
        end else begin
          wd_next = wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RAMP: begin
        // An emergency arriving during a disable ramp turns its end into a fault.
        if (emergency_off && (fault_code == FC_NONE)) begin
          fault_eff = FC_EMERG;
        end else begin
          fault_eff = fault_code;
        end
        fault_next = fault_eff;
        if (duty_out == 32'sd0) begin
          ramp_next = {RD_W{1'b0}};
          if (fault_eff != FC_NONE) begin
            fsm_next = ST_FAULT;
          end else begin
            fsm_next = ST_DISABLED;
          end
        end else if (ramp_cnt == RAMP_LAST) begin
          ramp_next   = {RD_W{1'b0}};
          duty_next   = ramp_toward_zero(duty_out);
          strobe_next = 1'b1;
        end else begin
          ramp_next = ramp_cnt + {{(RD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FAULT: begin
        duty_next = 32'sd0;
        if (clear_fault && !emergency_off) begin
          fsm_next   = ST_DISABLED;
          fault_next = FC_NONE;
        end else begin
          fsm_next = ST_FAULT;
        end
      end
      default: begin
        fsm_next   = ST_DISABLED;
        duty_next  = 32'sd0;
        fault_next = FC_NONE;
        wd_next    = {WD_W{1'b0}};
        ramp_next  = {RD_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_state   <= ST_DISABLED;
      duty_out    <= 32'sd0;
      duty_strobe <= 1'b0;
      fault_code  <= FC_NONE;
      wd_cnt      <= {WD_W{1'b0}};
      ramp_cnt    <= {RD_W{1'b0}};
    end else begin
      fsm_state   <= fsm_next;
      duty_out    <= duty_next;
      duty_strobe <= strobe_next;
      fault_code  <= fault_next;
      wd_cnt      <= wd_next;
      ramp_cnt    <= ramp_next;
    end
  end

endmodule
